// File: rtl/gpzda_transmitter.sv
// GPZDA sentence transmitter: BCD-converts day/month/year with double-dabble, then streams
// "$GPZDA,hhmmss.ss,dd,mm,yyyy,,*CS[CR LF]" one byte at a time over a valid/accept handshake.
module gpzda_transmitter #(
   parameter int unsigned B          = 8,
   parameter bit          AppendCrlf = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   output logic           ready,
   input  logic [9*B-1:0] utc,
   input  logic [2*B-1:0] day,
   input  logic [2*B-1:0] month,
   input  logic [2*B-1:0] year,
   output logic [B-1:0]   data,
   output logic           valid,
   input  logic           accept,
   output logic           done,
   output logic           error
);
   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StConvert = 3'd1;
   localparam logic [2:0] StSend    = 3'd2;
   localparam logic [2:0] StCheckHi = 3'd3;
   localparam logic [2:0] StCheckLo = 3'd4;
   localparam logic [2:0] StCr      = 3'd5;
   localparam logic [2:0] StLf      = 3'd6;
   localparam logic [2:0] StDone    = 3'd7;

   localparam int unsigned NumSteps = 2 * B;

   logic [2:0]     r_state;
   logic [9*B-1:0] r_utc;
   logic [2*B-1:0] r_bin_day, r_bin_month, r_bin_year;
   logic [7:0]     r_bcd_day, r_bcd_month;
   logic [15:0]    r_bcd_year;
   logic [5:0]     r_cnt;
   logic [4:0]     r_idx;
   logic [7:0]     r_csum;
   logic [B-1:0]   r_data;
   logic           r_valid;
   logic           r_error;

   logic           w_bad;
   logic [4:0]     w_next_idx;
   logic [3:0]     w_utc_k;
   logic [7:0]     w_utc_b [9];
   logic [7:0]     w_next_byte;

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   function automatic logic [15:0] f_dabble(input logic [15:0] bcd, input logic bit_in);
      logic [15:0] adj;
      for (int i = 0; i < 4; i++) begin
         adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
      return {adj[14:0], bit_in};
   endfunction

   function automatic logic [7:0] f_hex(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic logic [7:0] f_digit(input logic [3:0] n);
      return {4'h3, n};
   endfunction

   assign w_bad = (day > (2*B)'(99)) || (month > (2*B)'(99)) || (year > (2*B)'(9999));

   always_comb begin
      w_next_idx = r_idx + 5'd1;
      w_utc_k    = 4'(w_next_idx - 5'd7);
      for (int k = 0; k < 9; k++) begin
         w_utc_b[k] = 8'(r_utc[B*(8-k) +: B]);
      end
      case (w_next_idx)
         5'd1:  w_next_byte = "G";
         5'd2:  w_next_byte = "P";
         5'd3:  w_next_byte = "Z";
         5'd4:  w_next_byte = "D";
         5'd5:  w_next_byte = "A";
         5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
                w_next_byte = w_utc_b[w_utc_k];
         5'd6, 5'd16, 5'd19, 5'd22, 5'd27, 5'd28:
                w_next_byte = ",";
         5'd17: w_next_byte = f_digit(r_bcd_day[7:4]);
         5'd18: w_next_byte = f_digit(r_bcd_day[3:0]);
         5'd20: w_next_byte = f_digit(r_bcd_month[7:4]);
         5'd21: w_next_byte = f_digit(r_bcd_month[3:0]);
         5'd23: w_next_byte = f_digit(r_bcd_year[15:12]);
         5'd24: w_next_byte = f_digit(r_bcd_year[11:8]);
         5'd25: w_next_byte = f_digit(r_bcd_year[7:4]);
         5'd26: w_next_byte = f_digit(r_bcd_year[3:0]);
         5'd29: w_next_byte = "*";
         default: w_next_byte = "$";
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_utc       <= '0;
         r_bin_day   <= '0;
         r_bin_month <= '0;
         r_bin_year  <= '0;
         r_bcd_day   <= '0;
         r_bcd_month <= '0;
         r_bcd_year  <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_csum      <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_error <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_utc       <= utc;
                  r_bin_day   <= day;
                  r_bin_month <= month;
                  r_bin_year  <= year;
                  r_bcd_day   <= '0;
                  r_bcd_month <= '0;
                  r_bcd_year  <= '0;
                  r_cnt       <= '0;
                  if (w_bad) r_error <= 1'b1;
                  else       r_state <= StConvert;
               end
            end
            StConvert: begin
               if (r_cnt == 6'(NumSteps)) begin
                  r_state <= StSend;
                  r_idx   <= '0;
                  r_csum  <= '0;
                  r_valid <= 1'b1;
                  r_data  <= B'(8'h24);
               end else begin
                  r_bcd_day   <= 8'(f_dabble({8'h00, r_bcd_day}, r_bin_day[2*B-1]));
                  r_bcd_month <= 8'(f_dabble({8'h00, r_bcd_month}, r_bin_month[2*B-1]));
                  r_bcd_year  <= f_dabble(r_bcd_year, r_bin_year[2*B-1]);
                  r_bin_day   <= r_bin_day << 1;
                  r_bin_month <= r_bin_month << 1;
                  r_bin_year  <= r_bin_year << 1;
                  r_cnt       <= r_cnt + 6'd1;
               end
            end
            StSend: begin
               if (accept) begin
                  // "$" (index 0) and "*" (index 29) are outside the checksummed span.
                  if (r_idx != 5'd0 && r_idx != 5'd29) r_csum <= r_csum ^ 8'(r_data);
                  if (r_idx == 5'd29) begin
                     r_state <= StCheckHi;
                     r_data  <= B'(f_hex(r_csum[7:4]));
                  end else begin
                     r_idx  <= w_next_idx;
                     r_data <= B'(w_next_byte);
                  end
               end
            end
            StCheckHi: begin
               if (accept) begin
                  r_state <= StCheckLo;
                  r_data  <= B'(f_hex(r_csum[3:0]));
               end
            end
            StCheckLo: begin
               if (accept) begin
                  if (AppendCrlf) begin
                     r_state <= StCr;
                     r_data  <= B'(8'h0D);
                  end else begin
                     r_state <= StDone;
                     r_valid <= 1'b0;
                     r_data  <= '0;
                  end
               end
            end
            StCr: begin
               if (accept) begin
                  r_state <= StLf;
                  r_data  <= B'(8'h0A);
               end
            end
            StLf: begin
               if (accept) begin
                  r_state <= StDone;
                  r_valid <= 1'b0;
                  r_data  <= '0;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign ready = (r_state == StIdle);
   assign done  = (r_state == StDone);
   assign valid = r_valid;
   assign data  = r_data;
   assign error = r_error;

endmodule

// File: tb/tb_gpzda_transmitter.sv
// Randomised bench for gpzda_transmitter: expected sentences are formatted from the fields
// with $sformatf and a string XOR, then compared byte by byte against the accepted stream.
module tb_gpzda_transmitter;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        ready;
   logic [71:0] utc = '0;
   logic [15:0] day = '0;
   logic [15:0] month = '0;
   logic [15:0] year = '0;
   logic [7:0]  data;
   logic        valid;
   logic        accept = 1'b1;
   logic        done;
   logic        error;

   int          n_total = 0;
   int          n_bad = 0;
   logic [7:0]  got [$];

   gpzda_transmitter #(.B(8), .AppendCrlf(1'b1)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .ready  (ready),
      .utc    (utc),
      .day    (day),
      .month  (month),
      .year   (year),
      .data   (data),
      .valid  (valid),
      .accept (accept),
      .done   (done),
      .error  (error)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] hex_ch(input logic [3:0] n);
      string digits = "0123456789ABCDEF";
      return digits[n];
   endfunction

   function automatic string make_sentence(input string u, input int d, input int m,
                                           input int y);
      string      body;
      logic [7:0] cs = 8'h00;
      body = $sformatf("GPZDA,%s,%02d,%02d,%04d,,", u, d, m, y);
      for (int i = 0; i < body.len(); i++) cs ^= body[i];
      return {"$", body, "*", $sformatf("%c%c", hex_ch(cs[7:4]), hex_ch(cs[3:0])), "\015\012"};
   endfunction

   function automatic logic [71:0] utc_vec(input string s);
      logic [71:0] v;
      for (int k = 0; k < 9; k++) v[8*(8-k) +: 8] = s[k];
      return v;
   endfunction

   function automatic string rand_utc();
      return $sformatf("%02d%02d%02d.%02d", $urandom_range(0, 23), $urandom_range(0, 59),
                       $urandom_range(0, 59), $urandom_range(0, 99));
   endfunction

   function automatic int hex_val(input logic [7:0] c);
      return (c >= 8'h41) ? int'(c) - 55 : int'(c) - 48;
   endfunction

   task automatic run_sentence(input string tag, input string u, input int d, input int m,
                               input int y, input string exp_s, input bit rnd_acc,
                               input bit hold, input int abort_n);
      int         first_v = -1;
      int         done_cyc = -1;
      int         done_n = 0;
      int         last_acc = -1;
      int         gaps = 0;
      bit         prev_hold = 1'b0;
      logic [7:0] prev_data = 8'h00;
      logic       rdy1 = 1'b0;
      logic       rdy2 = 1'b0;
      got.delete();
      @(posedge clock);
      #1;
      utc   = utc_vec(u);
      day   = 16'(d);
      month = 16'(m);
      year  = 16'(y);
      start = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clock);
         #1;
         start  = hold;
         accept = rnd_acc ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clock);
         if (prev_hold) check_eq({tag, "/hold"}, {valid, data}, {1'b1, prev_data});
         if (valid && first_v < 0) first_v = cyc;
         if (first_v >= 0 && done_cyc < 0 && !valid && !done) gaps++;
         if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) rdy1 = ready;
         if (done_cyc >= 0 && cyc == done_cyc + 2) rdy2 = ready;
         prev_hold = valid && !accept;
         prev_data = data;
         if (valid && accept) begin
            got.push_back(data);
            last_acc = cyc;
            if (abort_n > 0 && got.size() == abort_n) break;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      end
      if (abort_n > 0) begin
         check_eq({tag, "/prefix_len"}, got.size(), abort_n);
         for (int i = 0; i < got.size(); i++)
            check_eq($sformatf("%s/byte%0d", tag, i), got[i], exp_s[i]);
      end else begin
         check_eq({tag, "/finished"}, done_cyc >= 0, 1);
         check_eq({tag, "/len"}, got.size(), exp_s.len());
         for (int i = 0; i < got.size() && i < exp_s.len(); i++)
            check_eq($sformatf("%s/byte%0d", tag, i), got[i], exp_s[i]);
         check_eq({tag, "/done_n"}, done_n, 1);
         check_eq({tag, "/done_after_last"}, done_cyc, last_acc + 1);
         check_eq({tag, "/no_gap"}, gaps, 0);
         check_eq({tag, "/ready_after"}, rdy1, 1'b1);
         check_eq({tag, "/restart"}, rdy2, !hold);
         if (!rnd_acc) begin
            check_eq({tag, "/first_valid"}, first_v, 17);
            check_eq({tag, "/done_cyc"}, done_cyc, 16 + 34 + 1);
         end
      end
   endtask

   task automatic err_case(input string tag, input int d, input int m, input int y);
      int seen_v = 0;
      int extra_err = 0;
      @(posedge clock);
      #1;
      day    = 16'(d);
      month  = 16'(m);
      year   = 16'(y);
      start  = 1'b1;
      accept = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(negedge clock);
      check_eq({tag, "/error"}, error, 1'b1);
      check_eq({tag, "/ready"}, ready, 1'b1);
      for (int i = 0; i < 24; i++) begin
         @(negedge clock);
         if (valid) seen_v++;
         if (error) extra_err++;
      end
      check_eq({tag, "/no_valid"}, seen_v, 0);
      check_eq({tag, "/single_pulse"}, extra_err, 0);
      check_eq({tag, "/still_ready"}, ready, 1'b1);
   endtask

   initial begin
      string      u;
      int         d, m, y;
      logic [7:0] cs_x;
      int         pd, pm, py;

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("rst/ready", ready, 1'b1);
      check_eq("rst/valid", valid, 1'b0);
      check_eq("rst/data", data, 8'h00);
      check_eq("rst/done", done, 1'b0);
      check_eq("rst/error", error, 1'b0);

      run_sentence("known", "123456.78", 9, 10, 2021,
                   "$GPZDA,123456.78,09,10,2021,,*67\015\012", 1'b0, 1'b0, 0);

      // Decode the stream the way a receiver would.
      pd = (int'(got[17]) - 48) * 10 + (int'(got[18]) - 48);
      pm = (int'(got[20]) - 48) * 10 + (int'(got[21]) - 48);
      py = 0;
      for (int i = 23; i < 27; i++) py = py * 10 + (int'(got[i]) - 48);
      cs_x = 8'h00;
      for (int i = 1; i < 29; i++) cs_x ^= got[i];
      check_eq("loop/day", pd, 9);
      check_eq("loop/month", pm, 10);
      check_eq("loop/year", py, 2021);
      check_eq("loop/checksum", hex_val(got[30]) * 16 + hex_val(got[31]), cs_x);

      run_sentence("known_rnd", "123456.78", 9, 10, 2021,
                   "$GPZDA,123456.78,09,10,2021,,*67\015\012", 1'b1, 1'b0, 0);

      run_sentence("zeros", "000000.00", 0, 0, 0,
                   make_sentence("000000.00", 0, 0, 0), 1'b0, 1'b0, 0);

      err_case("err_year", 9, 10, 10000);
      err_case("err_day", 100, 10, 2021);

      u = rand_utc();
      run_sentence("abort", u, 31, 12, 1999, make_sentence(u, 31, 12, 1999), 1'b0, 1'b0, 12);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("abort/valid", valid, 1'b0);
      check_eq("abort/ready", ready, 1'b1);
      run_sentence("after_abort", u, 31, 12, 1999, make_sentence(u, 31, 12, 1999),
                   1'b1, 1'b0, 0);

      u = rand_utc();
      run_sentence("held", u, 1, 2, 345, make_sentence(u, 1, 2, 345), 1'b0, 1'b1, 0);
      start = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check_eq("held/reset_ready", ready, 1'b1);

      for (int t = 0; t < 5; t++) begin
         u = rand_utc();
         d = $urandom_range(0, 99);
         m = $urandom_range(0, 99);
         y = $urandom_range(0, 9999);
         run_sentence($sformatf("rand%0d", t), u, d, m, y, make_sentence(u, d, m, y),
                      1'($urandom_range(0, 1)), 1'b0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
